// File: rtl/buffer_pkg.sv
// Shared constants and helpers for the buffer_fifo block and its bench.
package buffer_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;
    localparam int unsigned DEPTH_MIN = 2;
    localparam int unsigned DEPTH_MAX = 256;

    // Ceiling log2; clog2(n) bits index n distinct values (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/buffer_mem.sv
// Storage array for buffer_fifo: one synchronous write port, one asynchronous read port, no reset.
module buffer_mem #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/buffer_fifo.sv
// Valid/ready FIFO buffer with arbitrary (non power-of-two) depth.
// Optional macro BUFFER_LEVEL_EN adds the level and almost_full outputs.
module buffer_fifo
    import buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inp,
    input  logic             inp_valid,
    output logic             inp_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BUFFER_LEVEL_EN
    ,
    output logic [clog2(DEPTH+1)-1:0] level,
    output logic                      almost_full
`endif
);

    localparam int unsigned CW = clog2(DEPTH + 1);
    localparam int unsigned AW = clog2(DEPTH);

    // Reject out-of-range configurations at elaboration.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_param
        $error("buffer_fifo: WIDTH or DEPTH out of range");
    end

    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rd_data;

    // Handshake outputs depend only on the registered count.
    assign inp_ready = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = inp_valid & inp_ready;
    assign pop       = out_valid & out_ready;

    // Storage is not reset, so mask the head to zero while empty.
    assign out = out_valid ? rd_data : '0;

    // Next pointers wrap by explicit compare; count tracks push/pop balance.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (inp),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

`ifdef BUFFER_LEVEL_EN
    logic almost_full_q, almost_full_d;

    // Flag one slot short of full, computed from the next count.
    always_comb begin
        almost_full_d = (count_d >= CW'(DEPTH - 1));
    end

    // Almost-full register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign level       = count_q;
    assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_buffer_fifo.sv
// Self-checking bench for buffer_fifo (DEPTH=4 and DEPTH=3 instances, WIDTH=8).
module tb_buffer_fifo;
    import buffer_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D4 = 4;
    localparam int unsigned D3 = 3;
    localparam int NV = 22;

    typedef struct packed {
        logic         iv;
        logic [7:0]   d;
        logic         rdy;
        logic [2:0]   cnt;
        logic [7:0]   exp_out;
        logic         chk_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [W-1:0] inp4, out4, inp3, out3;
    logic         iv4, ir4, ov4, or4;
    logic         iv3, ir3, ov3, or3;
`ifdef BUFFER_LEVEL_EN
    logic [clog2(D4+1)-1:0] level4;
    logic [clog2(D3+1)-1:0] level3;
    logic                   af4, af3;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    buffer_fifo #(.WIDTH(W), .DEPTH(D4)) u_d4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .inp         (inp4),
        .inp_valid   (iv4),
        .inp_ready   (ir4),
        .out         (out4),
        .out_valid   (ov4),
        .out_ready   (or4)
`ifdef BUFFER_LEVEL_EN
        ,
        .level       (level4),
        .almost_full (af4)
`endif
    );

    buffer_fifo #(.WIDTH(W), .DEPTH(D3)) u_d3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .inp         (inp3),
        .inp_valid   (iv3),
        .inp_ready   (ir3),
        .out         (out3),
        .out_valid   (ov3),
        .out_ready   (or3)
`ifdef BUFFER_LEVEL_EN
        ,
        .level       (level3),
        .almost_full (af3)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic rdy,
                                input logic [2:0] cnt, input logic [7:0] eo, input logic chk);
        vec_t v;
        v.iv      = iv;
        v.d       = d;
        v.rdy     = rdy;
        v.cnt     = cnt;
        v.exp_out = eo;
        v.chk_out = chk;
        return v;
    endfunction

    task automatic step4(input logic iv, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        iv4  = iv;
        inp4 = d;
        or4  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic iv, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        iv3  = iv;
        inp3 = d;
        or3  = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inputs this cycle -> expected count and head after the edge
        vecs[0]  = mk(1'b1, 8'hA5, 1'b1, 3'd1, 8'hA5, 1'b1);
        vecs[1]  = mk(1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0);
        vecs[2]  = mk(1'b1, 8'h01, 1'b0, 3'd1, 8'h01, 1'b1);
        vecs[3]  = mk(1'b1, 8'h02, 1'b0, 3'd2, 8'h01, 1'b1);
        vecs[4]  = mk(1'b1, 8'h03, 1'b0, 3'd3, 8'h01, 1'b1);
        vecs[5]  = mk(1'b1, 8'h04, 1'b0, 3'd4, 8'h01, 1'b1);
        vecs[6]  = mk(1'b1, 8'h05, 1'b0, 3'd4, 8'h01, 1'b1);
        vecs[7]  = mk(1'b1, 8'h06, 1'b1, 3'd3, 8'h02, 1'b1);
        vecs[8]  = mk(1'b0, 8'h00, 1'b1, 3'd2, 8'h03, 1'b1);
        vecs[9]  = mk(1'b0, 8'h00, 1'b1, 3'd1, 8'h04, 1'b1);
        vecs[10] = mk(1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0);
        vecs[11] = mk(1'b1, 8'h11, 1'b0, 3'd1, 8'h11, 1'b1);
        vecs[12] = mk(1'b1, 8'h22, 1'b1, 3'd1, 8'h22, 1'b1);
        vecs[13] = mk(1'b1, 8'h33, 1'b1, 3'd1, 8'h33, 1'b1);
        vecs[14] = mk(1'b0, 8'hFF, 1'b0, 3'd1, 8'h33, 1'b1);
        vecs[15] = mk(1'b0, 8'hFF, 1'b1, 3'd0, 8'h00, 1'b0);
        vecs[16] = mk(1'b1, 8'h44, 1'b0, 3'd1, 8'h44, 1'b1);
        vecs[17] = mk(1'b1, 8'h55, 1'b0, 3'd2, 8'h44, 1'b1);
        vecs[18] = mk(1'b1, 8'h66, 1'b0, 3'd3, 8'h44, 1'b1);
        vecs[19] = mk(1'b0, 8'h00, 1'b1, 3'd2, 8'h55, 1'b1);
        vecs[20] = mk(1'b0, 8'h00, 1'b1, 3'd1, 8'h66, 1'b1);
        vecs[21] = mk(1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0);

        rst_n = 1'b0;
        iv4 = 1'b0; inp4 = '0; or4 = 1'b0;
        iv3 = 1'b0; inp3 = '0; or3 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst inp_ready", 64'(ir4), 64'(1));
        check("rst out_valid", 64'(ov4), 64'(0));
        check("rst out", 64'(out4), 64'(0));
        check("rst d3 inp_ready", 64'(ir3), 64'(1));
        check("rst d3 out_valid", 64'(ov3), 64'(0));
`ifdef BUFFER_LEVEL_EN
        check("rst level", 64'(level4), 64'(0));
        check("rst almost_full", 64'(af4), 64'(0));
`endif
        rst_n = 1'b1;

        // Table-driven: basic path, full, push+pop when full, drain, streaming, level
        for (int i = 0; i < NV; i++) begin
            step4(vecs[i].iv, vecs[i].d, vecs[i].rdy);
            check($sformatf("v%0d inp_ready", i), 64'(ir4), 64'(vecs[i].cnt < 3'd4));
            check($sformatf("v%0d out_valid", i), 64'(ov4), 64'(vecs[i].cnt != 3'd0));
            if (vecs[i].chk_out) begin
                check($sformatf("v%0d out", i), 64'(out4), 64'(vecs[i].exp_out));
            end
`ifdef BUFFER_LEVEL_EN
            check($sformatf("v%0d level", i), 64'(level4), 64'(vecs[i].cnt));
            check($sformatf("v%0d almost_full", i), 64'(af4), 64'(vecs[i].cnt >= 3'd3));
`endif
        end

        // Mid-operation reset with two entries held
        step4(1'b1, 8'h77, 1'b0);
        step4(1'b1, 8'h88, 1'b0);
        check("pre-rst out_valid", 64'(ov4), 64'(1));
        check("pre-rst out", 64'(out4), 64'(8'h77));
        @(negedge clk);
        iv4 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(ov4), 64'(0));
        check("midrst inp_ready", 64'(ir4), 64'(1));
        check("midrst out", 64'(out4), 64'(0));
`ifdef BUFFER_LEVEL_EN
        check("midrst level", 64'(level4), 64'(0));
        check("midrst almost_full", 64'(af4), 64'(0));
`endif
        #2;
        rst_n = 1'b1;
        iv4 = 1'b1; inp4 = 8'h07; or4 = 1'b0;
        @(posedge clk);
        #1;
        check("postrst out_valid", 64'(ov4), 64'(1));
        check("postrst out", 64'(out4), 64'(8'h07));
        step4(1'b0, 8'h00, 1'b1);
        check("postrst drain out_valid", 64'(ov4), 64'(0));

        // DEPTH=3 streaming: 0..9 through the buffer, pointers wrap 2->0
        for (int k = 0; k < 10; k++) begin
            step3(1'b1, 8'(k), 1'b1);
            check($sformatf("wrap%0d out_valid", k), 64'(ov3), 64'(1));
            check($sformatf("wrap%0d out", k), 64'(out3), 64'(k));
            check($sformatf("wrap%0d inp_ready", k), 64'(ir3), 64'(1));
        end
        step3(1'b0, 8'h00, 1'b1);
        check("wrap end out_valid", 64'(ov3), 64'(0));

        // DEPTH=3 fill and drain starting from a wrapped pointer position
        step3(1'b1, 8'hAA, 1'b0);
        step3(1'b1, 8'hBB, 1'b0);
        step3(1'b1, 8'hCC, 1'b0);
        check("d3 full inp_ready", 64'(ir3), 64'(0));
        check("d3 full out", 64'(out3), 64'(8'hAA));
`ifdef BUFFER_LEVEL_EN
        check("d3 full level", 64'(level3), 64'(3));
        check("d3 full almost_full", 64'(af3), 64'(1));
`endif
        step3(1'b1, 8'hDD, 1'b0);
        check("d3 reject inp_ready", 64'(ir3), 64'(0));
        step3(1'b0, 8'h00, 1'b1);
        check("d3 drain1 out", 64'(out3), 64'(8'hBB));
        check("d3 drain1 inp_ready", 64'(ir3), 64'(1));
        step3(1'b0, 8'h00, 1'b1);
        check("d3 drain2 out", 64'(out3), 64'(8'hCC));
        step3(1'b0, 8'h00, 1'b1);
        check("d3 drain3 out_valid", 64'(ov3), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
